aes_spi_bridge: RTL



---
 rtl/aes_spi_pkg.sv | 21 ++
 rtl/spi_shift_reg.sv | 34 +++
 rtl/aes_spi_bridge.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES serial bridge: FSM state encoding
// and the set of key widths the bridge accepts.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RDY,
        ST_UNLOAD
    } state_e;

    localparam int KEY_W_128 = 128;
    localparam int KEY_W_192 = 192;
    localparam int KEY_W_256 = 256;

    function automatic bit key_w_legal(input int w);
        return (w == KEY_W_128) || (w == KEY_W_192) || (w == KEY_W_256);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in/serial-out shift register with parallel load; bit order chosen by
// MSB_FIRST (first bit in/out lands on or leaves from bit W-1 when set).
module spi_shift_reg
    import aes_spi_pkg::*;
#(
    parameter int W         = 128,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] d_par,
    input  logic         sdi,
    output logic [W-1:0] q_par,
    output logic         sdo
);

    logic [W-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= d_par;
        end else if (en) begin
            sr_q <= MSB_FIRST ? {sr_q[W-2:0], sdi} : {sdi, sr_q[W-1:1]};
        end
    end

    assign q_par = sr_q;
    assign sdo   = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/aes_spi_bridge.sv
// Serial front-end for the AES core: loads key + message over a cs frame,
// hands them over with a valid pulse, then shifts the core's result back out.
module aes_spi_bridge
    import aes_spi_pkg::*;
#(
    parameter int KEY_W     = 256,
    parameter int BLK_W     = 128,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             key_sdi,
    input  logic             msg_sdi,
    output logic             res_sdo,
    output logic [KEY_W-1:0] key_out,
    output logic [BLK_W-1:0] msg_out,
    output logic             load_valid,
    input  logic [BLK_W-1:0] result_in,
    input  logic             result_valid,
    output logic             done,
    output logic             frame_err,
    output logic             busy
);

    if (!key_w_legal(KEY_W)) begin : g_key_w_check
        $error("aes_spi_bridge: KEY_W must be 128, 192 or 256");
    end

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_W - 1);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLK_W);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cs_q;
    logic [KEY_W-1:0] key_out_q;
    logic [BLK_W-1:0] msg_out_q;
    logic             load_valid_q;
    logic             done_q;
    logic             frame_err_q;

    logic             rise;
    logic             key_smp;
    logic             msg_smp;
    logic             res_ld;
    logic             res_shift;
    logic [KEY_W-1:0] key_sr;
    logic [BLK_W-1:0] msg_sr;
    logic [KEY_W-1:0] key_next;
    logic [BLK_W-1:0] msg_next;
    logic             res_bit;
    logic             key_sdo_unused;
    logic             msg_sdo_unused;
    logic [BLK_W-1:0] res_par_unused;

    assign rise      = cs & ~cs_q;
    assign key_smp   = ((state_q == ST_IDLE) & rise) | ((state_q == ST_LOAD) & cs);
    assign msg_smp   = key_smp & (cnt_q < BLK_CNT);
    assign res_ld    = (state_q == ST_WAIT) & result_valid;
    assign res_shift = ((state_q == ST_RDY) & rise) | ((state_q == ST_UNLOAD) & cs);

    // The last bit arrives on the same edge that publishes the word, so the
    // published value is the shift register's next state, not its current one.
    assign key_next = MSB_FIRST ? {key_sr[KEY_W-2:0], key_sdi} : {key_sdi, key_sr[KEY_W-1:1]};
    assign msg_next = !msg_smp ? msg_sr
                    : (MSB_FIRST ? {msg_sr[BLK_W-2:0], msg_sdi} : {msg_sdi, msg_sr[BLK_W-1:1]});

    spi_shift_reg #(.W(KEY_W), .MSB_FIRST(MSB_FIRST)) u_key_sr (
        .clk   (clk),
        .rst   (rst),
        .en    (key_smp),
        .load  (1'b0),
        .d_par ('0),
        .sdi   (key_sdi),
        .q_par (key_sr),
        .sdo   (key_sdo_unused)
    );

    spi_shift_reg #(.W(BLK_W), .MSB_FIRST(MSB_FIRST)) u_msg_sr (
        .clk   (clk),
        .rst   (rst),
        .en    (msg_smp),
        .load  (1'b0),
        .d_par ('0),
        .sdi   (msg_sdi),
        .q_par (msg_sr),
        .sdo   (msg_sdo_unused)
    );

    spi_shift_reg #(.W(BLK_W), .MSB_FIRST(MSB_FIRST)) u_res_sr (
        .clk   (clk),
        .rst   (rst),
        .en    (res_shift),
        .load  (res_ld),
        .d_par (result_in),
        .sdi   (1'b0),
        .q_par (res_par_unused),
        .sdo   (res_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cs_q         <= 1'b0;
            key_out_q    <= '0;
            msg_out_q    <= '0;
            load_valid_q <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cs_q         <= cs;
            load_valid_q <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // The rise cycle already carries bit 0, so LOAD resumes at 1.
                    if (rise) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    if (!cs) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                    end else if (cnt_q == KEY_LAST) begin
                        key_out_q    <= key_next;
                        msg_out_q    <= msg_next;
                        load_valid_q <= 1'b1;
                        state_q      <= ST_WAIT;
                        cnt_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (result_valid) begin
                        state_q <= ST_RDY;
                    end
                end
                ST_RDY: begin
                    if (rise) begin
                        state_q <= ST_UNLOAD;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (!cs) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                    end else if (cnt_q == BLK_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign res_sdo    = ((state_q == ST_RDY) || (state_q == ST_UNLOAD)) ? res_bit : 1'b0;
    assign key_out    = key_out_q;
    assign msg_out    = msg_out_q;
    assign load_valid = load_valid_q;
    assign done       = done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
